// File: rtl/coin_input_ctrl_if.sv
// Button/coin front-end bundle between the board pins and the vending FSM.
// The master drives raw inputs and the slow tick; the slave returns held requests.
interface coin_input_ctrl_if;
    logic       insert;
    logic [1:0] coin_val;
    logic       cancel_flag;
    logic       slow_tick;
    logic       insert_req;
    logic [1:0] coin_val_q;
    logic       cancel_req;
    logic       coin_err;
    logic       busy;

    modport master (
        output insert, coin_val, cancel_flag, slow_tick,
        input  insert_req, coin_val_q, cancel_req, coin_err, busy
    );

    modport slave (
        input  insert, coin_val, cancel_flag, slow_tick,
        output insert_req, coin_val_q, cancel_req, coin_err, busy
    );
endinterface

// File: rtl/coin_input_ctrl.sv
// Synchronises and debounces insert/cancel buttons, latches the coin value and
// holds each accepted request until the slow FSM clock has sampled it.
module coin_input_ctrl #(
    parameter int unsigned DEB_CYCLES = 1_000_000,
    parameter int unsigned CNT_W      = 20
) (
    input  logic             clk100MHZ,
    input  logic             rst_n,
    coin_input_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        ACCEPT,
        WAIT_REL,
        REL_DB
    } btn_st_e;

    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       rst_ff_q;
    logic             rst_s_n;
    logic [1:0]       ins_ff_q;
    logic [1:0]       can_ff_q;
    logic [1:0]       coin_s1_q;
    logic [1:0]       coin_s2_q;
    logic [1:0]       btn;

    btn_st_e          st_q  [2];
    btn_st_e          st_d  [2];
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       acc;

    logic             ins_req_q, ins_req_d;
    logic             can_req_q, can_req_d;
    logic             ins_arm_q, ins_arm_d;
    logic             can_arm_q, can_arm_d;
    logic [1:0]       coin_val_q, coin_val_d;
    logic             coin_err_q, coin_err_d;

    // Reset: asserted immediately, released two clocks later
    always_ff @(posedge clk100MHZ or negedge rst_n) begin
        if (!rst_n) rst_ff_q <= 2'b00;
        else        rst_ff_q <= {rst_ff_q[0], 1'b1};
    end

    assign rst_s_n = rst_ff_q[1];

    // Two-flop synchronisers for the raw board inputs
    always_ff @(posedge clk100MHZ or negedge rst_s_n) begin
        if (!rst_s_n) begin
            ins_ff_q  <= 2'b00;
            can_ff_q  <= 2'b00;
            coin_s1_q <= 2'b00;
            coin_s2_q <= 2'b00;
        end else begin
            ins_ff_q  <= {ins_ff_q[0], bus.insert};
            can_ff_q  <= {can_ff_q[0], bus.cancel_flag};
            coin_s1_q <= bus.coin_val;
            coin_s2_q <= coin_s1_q;
        end
    end

    assign btn = {can_ff_q[1], ins_ff_q[1]};

    // Debounce FSMs: index 0 is insert, index 1 is cancel
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            acc[i]   = 1'b0;
            unique case (st_q[i])
                IDLE: begin
                    if (btn[i]) begin
                        st_d[i]  = PRESS_DB;
                        cnt_d[i] = '0;
                    end
                end
                PRESS_DB: begin
                    if (!btn[i])                 st_d[i]  = IDLE;
                    else if (cnt_q[i] == CNT_END) st_d[i]  = ACCEPT;
                    else if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
                end
                ACCEPT: begin
                    acc[i]  = 1'b1;
                    st_d[i] = WAIT_REL;
                end
                WAIT_REL: begin
                    if (!btn[i]) begin
                        st_d[i]  = REL_DB;
                        cnt_d[i] = '0;
                    end
                end
                REL_DB: begin
                    if (btn[i])                   st_d[i]  = WAIT_REL;
                    else if (cnt_q[i] == CNT_END) st_d[i]  = IDLE;
                    else if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
                end
                default: st_d[i] = IDLE;
            endcase
        end
    end

    // Request hold/consume: cancel has priority, a pending request blocks new ones
    always_comb begin
        ins_req_d  = ins_req_q;
        can_req_d  = can_req_q;
        coin_val_d = coin_val_q;
        coin_err_d = 1'b0;
        if (ins_req_q && ins_arm_q && bus.slow_tick) ins_req_d = 1'b0;
        if (can_req_q && can_arm_q && bus.slow_tick) can_req_d = 1'b0;
        if (acc[1] && !can_req_q) can_req_d = 1'b1;
        if (acc[0]) begin
            if (coin_s2_q == 2'b00) begin
                coin_err_d = 1'b1;
            end else if (!ins_req_q && !can_req_q && !acc[1]) begin
                ins_req_d  = 1'b1;
                coin_val_d = coin_s2_q;
            end
        end
        ins_arm_d = ins_req_q & ins_req_d;
        can_arm_d = can_req_q & can_req_d;
    end

    // State and output registers
    always_ff @(posedge clk100MHZ or negedge rst_s_n) begin
        if (!rst_s_n) begin
            st_q[0]    <= IDLE;
            st_q[1]    <= IDLE;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            ins_req_q  <= 1'b0;
            can_req_q  <= 1'b0;
            ins_arm_q  <= 1'b0;
            can_arm_q  <= 1'b0;
            coin_val_q <= 2'b00;
            coin_err_q <= 1'b0;
        end else begin
            st_q[0]    <= st_d[0];
            st_q[1]    <= st_d[1];
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            ins_req_q  <= ins_req_d;
            can_req_q  <= can_req_d;
            ins_arm_q  <= ins_arm_d;
            can_arm_q  <= can_arm_d;
            coin_val_q <= coin_val_d;
            coin_err_q <= coin_err_d;
        end
    end

    assign bus.insert_req = ins_req_q;
    assign bus.coin_val_q = coin_val_q;
    assign bus.cancel_req = can_req_q;
    assign bus.coin_err   = coin_err_q;
    assign bus.busy       = ins_req_q | can_req_q
                          | (st_q[0] != IDLE) | (st_q[1] != IDLE);

endmodule

// File: tb/tb_coin_input_ctrl.sv
// Bench for coin_input_ctrl with a short debounce window.
// Expected requests are queued at stimulus time and popped on output edges.
module tb_coin_input_ctrl;

    localparam int DEB = 8;
    localparam int LAT = 2 + DEB + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tot = 0;
    int   n_bad = 0;

    coin_input_ctrl_if bus ();

    coin_input_ctrl #(
        .DEB_CYCLES(DEB),
        .CNT_W     (4)
    ) dut (
        .clk100MHZ(clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [1:0] ins_q [$];
    int         can_q [$];
    int         err_q [$];
    int         ins_rises = 0;
    int         can_rises = 0;
    int         err_cnt   = 0;
    logic       ins_p = 1'b0;
    logic       can_p = 1'b0;
    logic [1:0] cv_p  = 2'b00;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: pop expectations whenever the DUT raises a request or error
    always @(negedge clk) begin
        if (bus.insert_req && !ins_p) begin
            ins_rises++;
            if (ins_q.size() == 0) chk("ins_unexp", 1, 0);
            else chk("ins_coin", bus.coin_val_q, ins_q.pop_front());
        end
        if (bus.insert_req && ins_p) chk("coin_hold", bus.coin_val_q, cv_p);
        if (bus.cancel_req && !can_p) begin
            can_rises++;
            if (can_q.size() == 0) chk("can_unexp", 1, 0);
            else void'(can_q.pop_front());
        end
        if (bus.coin_err) begin
            err_cnt++;
            if (err_q.size() == 0) chk("err_unexp", 1, 0);
            else void'(err_q.pop_front());
        end
        ins_p = bus.insert_req;
        can_p = bus.cancel_req;
        cv_p  = bus.coin_val_q;
    end

    initial begin
        int lat;
        bus.insert      = 1'b0;
        bus.coin_val    = 2'b00;
        bus.cancel_flag = 1'b0;
        bus.slow_tick   = 1'b0;

        // Reset state and mid-press reset
        @(negedge clk);
        chk("rst_ins", bus.insert_req, 0);
        chk("rst_can", bus.cancel_req, 0);
        chk("rst_err", bus.coin_err, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cv", bus.coin_val_q, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        bus.coin_val = 2'b01;
        bus.insert   = 1'b1;
        repeat (6) @(negedge clk);
        chk("pre_busy", bus.busy, 1);
        rst_n      = 1'b0;
        bus.insert = 1'b0;
        #1;
        chk("mid_busy", bus.busy, 0);
        chk("mid_ins", bus.insert_req, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_ins", bus.insert_req, 0);
        chk("post_busy", bus.busy, 0);

        // Bounce then steady press
        bus.coin_val = 2'b10;
        for (int i = 0; i < 14; i++) begin
            bus.insert = ~bus.insert;
            repeat (3) @(negedge clk);
        end
        ins_q.push_back(2'b10);
        bus.insert = 1'b1;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus.insert_req) begin
                lat = k;
                break;
            end
        end
        chk("bounce_lat", lat, LAT);

        // Tick in raise cycle is ignored; tick at +5 consumes
        bus.slow_tick = 1'b1;
        @(negedge clk);
        bus.slow_tick = 1'b0;
        chk("raise_tick", bus.insert_req, 1);
        repeat (4) @(negedge clk);
        chk("hold5", bus.insert_req, 1);
        bus.slow_tick = 1'b1;
        @(negedge clk);
        bus.slow_tick = 1'b0;
        chk("clr6", bus.insert_req, 0);
        bus.insert = 1'b0;
        repeat (20) @(negedge clk);

        // Invalid coin
        bus.coin_val = 2'b00;
        err_q.push_back(1);
        bus.insert = 1'b1;
        repeat (15) @(negedge clk);
        bus.insert = 1'b0;
        repeat (20) @(negedge clk);
        chk("inv_req", bus.insert_req, 0);

        // Collision: cancel wins, later insert dropped while cancel pending
        bus.coin_val = 2'b01;
        can_q.push_back(1);
        bus.insert      = 1'b1;
        bus.cancel_flag = 1'b1;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus.cancel_req) begin
                lat = k;
                break;
            end
        end
        chk("col_lat", lat, LAT);
        chk("col_ins", bus.insert_req, 0);
        bus.insert      = 1'b0;
        bus.cancel_flag = 1'b0;
        repeat (15) @(negedge clk);
        bus.coin_val = 2'b11;
        bus.insert   = 1'b1;
        repeat (15) @(negedge clk);
        bus.insert = 1'b0;
        repeat (20) @(negedge clk);
        chk("drop_ins", bus.insert_req, 0);
        chk("can_pend", bus.cancel_req, 1);
        bus.slow_tick = 1'b1;
        @(negedge clk);
        bus.slow_tick = 1'b0;
        chk("can_clr", bus.cancel_req, 0);
        repeat (5) @(negedge clk);

        // Long hold with two ticks
        bus.coin_val = 2'b01;
        ins_q.push_back(2'b01);
        bus.insert = 1'b1;
        for (int c = 1; c <= 10 * DEB; c++) begin
            @(negedge clk);
            if (c == 29) chk("long_pend", bus.insert_req, 1);
            if (c == 31) chk("long_clr", bus.insert_req, 0);
            bus.slow_tick = (c == 30 || c == 50);
        end
        bus.slow_tick = 1'b0;
        bus.insert    = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("long_req", bus.insert_req, 0);
        chk("idle_busy", bus.busy, 0);
        chk("ins_left", ins_q.size(), 0);
        chk("can_left", can_q.size(), 0);
        chk("err_left", err_q.size(), 0);
        chk("ins_rises", ins_rises, 2);
        chk("can_rises", can_rises, 1);
        chk("err_cnt", err_cnt, 1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
